imm_encoder: RTL and testbench

Multi-cycle immediate encoder for the processor's instruction-generation path. It takes a 32-bit constant and an immediate format selector, and produces the instruction immediate field that the `extend` immediate extender decodes back to the same constant. It also reports whether that constant is encodable. The rotated 8-bit ARM form (4-bit rotate plus imm8) is found by a sequential search, one rotation per cycle. It sits beside the assembler/patch logic that writes instruction words.

---
 rtl/imm_encoder_pkg.sv | 58 +++++
 rtl/imm_encoder_rol32.sv | 17 +
 rtl/imm_encoder.sv | 95 +++++++++
 tb/tb_imm_encoder.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/imm_encoder_pkg.sv
// Purpose: shared immediate-format and encoder-state typedefs plus the single-cycle format encoder.
// Latency: n/a (types and a pure function).
// Backpressure: n/a.
package imm_encoder_pkg;

    // Immediate format selector, shared with the extend decoder.
    typedef enum logic [1:0] {
        IMM8     = 2'b00,
        IMM12    = 2'b01,
        BRANCH24 = 2'b10,
        ROT8     = 2'b11
    } imm_src_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SEARCH = 2'b01,
        FINISH = 2'b10
    } state_t;

    // Last rotation tried before the search gives up.
    localparam logic [3:0] ROT_MAX = 4'd15;

    typedef struct packed {
        logic        ok;
        logic [23:0] field;
    } enc_t;

    // Encoding for the formats that need no search. Non-encodable values
    // always yield a zero field.
    function automatic enc_t simple_encode(input logic [31:0] v, input imm_src_t src);
        enc_t e;
        e = '0;
        case (src)
            IMM8: begin
                if (v[31:8] == 24'd0) begin
                    e.ok    = 1'b1;
                    e.field = {16'd0, v[7:0]};
                end
            end
            IMM12: begin
                if (v[31:12] == 20'd0) begin
                    e.ok    = 1'b1;
                    e.field = {12'd0, v[11:0]};
                end
            end
            BRANCH24: begin
                // Word-aligned, and the top bits must be a sign extension of bit 25.
                if ((v[1:0] == 2'b00) && (v[31:25] == {7{v[25]}})) begin
                    e.ok    = 1'b1;
                    e.field = v[25:2];
                end
            end
            default: e = '0;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/imm_encoder_rol32.sv
// Purpose: combinational 32-bit rotate-left by a 5-bit amount (rotated-imm8 search datapath).
// Latency: 0 cycles, purely combinational.
// Backpressure: none.
// Ports: din (32) value, amt (5) rotate amount, dout (32) rotated value.
module rol32 (
    input  logic [31:0] din,
    input  logic [4:0]  amt,
    output logic [31:0] dout
);

    // Shifting the doubled word left makes the upper half the rotated value.
    logic [63:0] dbl;

    assign dbl  = {din, din} << amt;
    assign dout = dbl[63:32];

endmodule

// File: rtl/imm_encoder.sv
// Purpose: encode a 32-bit constant into an instruction immediate field (8/12-bit, branch24, rotated imm8).
// Latency: 1 cycle for simple formats; k+2 cycles for rotated imm8 matching at rotation k (17 worst case).
// Backpressure: start_i is only accepted in IDLE (busy_o low); starts while busy are dropped.
// Ports: clk_i, rst_ni (async active-low); start_i/value_i/imm_src_i request;
//        busy_o, done_o (1-cycle pulse), ok_o and field_o (held until the next done_o).
module imm_encoder
    import imm_encoder_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [31:0] value_i,
    input  logic [1:0]  imm_src_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        ok_o,
    output logic [23:0] field_o
);

    state_t      state;
    logic [31:0] value_q;
    logic [3:0]  rot_q;
    logic [31:0] rot_val;
    enc_t        simple_enc;

    // Rotate by twice the rotation index, the same amount the decoder undoes.
    rol32 u_rol32 (
        .din  (value_q),
        .amt  ({rot_q, 1'b0}),
        .dout (rot_val)
    );

    assign simple_enc = simple_encode(value_i, imm_src_t'(imm_src_i));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= IDLE;
            value_q <= 32'd0;
            rot_q   <= 4'd0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
            ok_o    <= 1'b0;
            field_o <= 24'd0;
        end else begin
            case (state)
                IDLE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        value_q <= value_i;
                        rot_q   <= 4'd0;
                        busy_o  <= 1'b1;
                        if (imm_src_i == ROT8) begin
                            state <= SEARCH;
                        end else begin
                            // Simple formats resolve directly from the request inputs,
                            // so the result is ready in the first cycle after start.
                            state   <= FINISH;
                            done_o  <= 1'b1;
                            ok_o    <= simple_enc.ok;
                            field_o <= simple_enc.field;
                        end
                    end
                end
                SEARCH: begin
                    // Rotations are tried in increasing order, so the first hit is the smallest.
                    if (rot_val[31:8] == 24'd0) begin
                        state   <= FINISH;
                        done_o  <= 1'b1;
                        ok_o    <= 1'b1;
                        field_o <= {12'd0, rot_q, rot_val[7:0]};
                    end else if (rot_q == ROT_MAX) begin
                        state   <= FINISH;
                        done_o  <= 1'b1;
                        ok_o    <= 1'b0;
                        field_o <= 24'd0;
                    end else begin
                        rot_q <= rot_q + 4'd1;
                    end
                end
                FINISH: begin
                    state  <= IDLE;
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                    rot_q  <= 4'd0;
                end
                default: begin
                    state  <= IDLE;
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imm_encoder.sv
module tb_imm_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] value = 32'd0;
    logic [1:0]  src = 2'b00;
    logic        busy_o;
    logic        done_o;
    logic        ok_o;
    logic [23:0] field_o;

    int npass = 0;
    int ntotal = 0;

    imm_encoder dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .start_i   (start),
        .value_i   (value),
        .imm_src_i (src),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .ok_o      (ok_o),
        .field_o   (field_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] value;
        logic [1:0]  src;
        int          lat;
        logic        ok;
        logic [23:0] field;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntotal++;
        if (act !== exp)
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        else
            npass++;
    endtask

    // Issue one request (start sampled at the next rising edge = edge 0) and wait
    // for done_o, sampling on falling edges. cyc is the cycle index of done_o
    // (-1 on timeout). If poke > 0, a conflicting start is driven in that cycle.
    task automatic run(input logic [31:0] v, input logic [1:0] s, input int poke,
                       output int cyc, output logic ok, output logic [23:0] f,
                       output logic busy1);
        @(negedge clk);
        start = 1'b1;
        value = v;
        src   = s;
        @(posedge clk);
        cyc   = -1;
        ok    = 1'b0;
        f     = 24'd0;
        busy1 = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == poke) begin
                start = 1'b1;
                value = 32'h0000_00AB;
                src   = 2'b00;
            end else begin
                start = 1'b0;
            end
            if (c == 1) busy1 = busy_o;
            if (done_o) begin
                cyc = c;
                ok  = ok_o;
                f   = field_o;
                break;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc;
        logic        ok;
        logic [23:0] f;
        logic        b1;
        int          seen;

        vecs[0]  = '{32'h0000_00AB, 2'b00,  1, 1'b1, 24'h0000AB};
        vecs[1]  = '{32'h0000_01AB, 2'b00,  1, 1'b0, 24'h000000};
        vecs[2]  = '{32'hFFFF_FFF8, 2'b10,  1, 1'b1, 24'hFFFFFE};
        vecs[3]  = '{32'h0200_0000, 2'b10,  1, 1'b0, 24'h000000};
        vecs[4]  = '{32'h0000_0006, 2'b10,  1, 1'b0, 24'h000000};
        vecs[5]  = '{32'hFF00_0000, 2'b11,  6, 1'b1, 24'h0004FF};
        vecs[6]  = '{32'h0000_0000, 2'b11,  2, 1'b1, 24'h000000};
        vecs[7]  = '{32'h0000_0104, 2'b11, 17, 1'b1, 24'h000F41};
        vecs[8]  = '{32'h0000_0101, 2'b11, 17, 1'b0, 24'h000000};
        vecs[9]  = '{32'h0000_0FFF, 2'b01,  1, 1'b1, 24'h000FFF};
        vecs[10] = '{32'h0000_1000, 2'b01,  1, 1'b0, 24'h000000};
        vecs[11] = '{32'h0000_00FF, 2'b11,  2, 1'b1, 24'h0000FF};
        vecs[12] = '{32'hC000_003F, 2'b11,  3, 1'b1, 24'h0001FF};

        // Reset state.
        #12;
        chk("reset_busy",  {31'd0, busy_o}, 32'd0);
        chk("reset_done",  {31'd0, done_o}, 32'd0);
        chk("reset_ok",    {31'd0, ok_o},   32'd0);
        chk("reset_field", {8'd0, field_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven vectors.
        foreach (vecs[i]) begin
            run(vecs[i].value, vecs[i].src, 0, cyc, ok, f, b1);
            chk($sformatf("vec%0d_latency", i), cyc, vecs[i].lat);
            chk($sformatf("vec%0d_ok", i), {31'd0, ok}, {31'd0, vecs[i].ok});
            chk($sformatf("vec%0d_field", i), {8'd0, f}, {8'd0, vecs[i].field});
            chk($sformatf("vec%0d_busy_c1", i), {31'd0, b1}, 32'd1);
        end

        // Start pulsed mid-search with a different request is ignored.
        run(32'hFF00_0000, 2'b11, 2, cyc, ok, f, b1);
        chk("ignore_latency", cyc, 6);
        chk("ignore_ok", {31'd0, ok}, 32'd1);
        chk("ignore_field", {8'd0, f}, 32'h0004FF);

        // Back-to-back 12-bit requests; start held through FINISH must not be taken early.
        @(negedge clk);
        start = 1'b1; value = 32'h0000_0FFF; src = 2'b01;
        @(negedge clk);                               // cycle 1
        chk("b2b_done_c1", {31'd0, done_o}, 32'd1);
        chk("b2b_ok_c1", {31'd0, ok_o}, 32'd1);
        chk("b2b_field_c1", {8'd0, field_o}, 32'h000FFF);
        value = 32'h0000_1000;                        // start stays high
        @(negedge clk);                               // cycle 2 (IDLE)
        chk("b2b_done_c2", {31'd0, done_o}, 32'd0);
        chk("b2b_busy_c2", {31'd0, busy_o}, 32'd0);
        chk("b2b_ok_hold_c2", {31'd0, ok_o}, 32'd1);
        chk("b2b_field_hold_c2", {8'd0, field_o}, 32'h000FFF);
        @(negedge clk);                               // cycle 3
        start = 1'b0;
        chk("b2b_done_c3", {31'd0, done_o}, 32'd1);
        chk("b2b_ok_c3", {31'd0, ok_o}, 32'd0);
        chk("b2b_field_c3", {8'd0, field_o}, 32'd0);
        @(negedge clk);                               // cycle 4
        chk("b2b_done_c4", {31'd0, done_o}, 32'd0);
        chk("b2b_ok_hold_c4", {31'd0, ok_o}, 32'd0);

        // Reset mid-search: first leave a nonzero result on the outputs.
        run(32'h0000_00FF, 2'b11, 0, cyc, ok, f, b1);
        chk("pre_reset_field", {8'd0, f}, 32'h0000FF);
        @(negedge clk);
        start = 1'b1; value = 32'h0000_0101; src = 2'b11;
        @(posedge clk);                               // edge 0
        @(negedge clk);                               // cycle 1
        start = 1'b0;
        @(negedge clk);                               // cycle 2
        @(negedge clk);                               // cycle 3
        rst_n = 1'b0;
        #1;
        chk("abort_busy",  {31'd0, busy_o}, 32'd0);
        chk("abort_done",  {31'd0, done_o}, 32'd0);
        chk("abort_ok",    {31'd0, ok_o},   32'd0);
        chk("abort_field", {8'd0, field_o}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done_o) seen++;
        end
        chk("abort_no_done", seen, 0);

        // Fresh request after reset completes normally.
        run(32'hC000_003F, 2'b11, 0, cyc, ok, f, b1);
        chk("post_reset_latency", cyc, 3);
        chk("post_reset_ok", {31'd0, ok}, 32'd1);
        chk("post_reset_field", {8'd0, f}, 32'h0001FF);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
